// File: rtl/intr_if.sv
// Interrupt controller bus: peripheral lines, mask programming and the
// request/acknowledge/return handshake with the control unit.
interface intr_if #(
  parameter int N_IRQ = 8,
  parameter int VEC_W = 10
);
  logic [N_IRQ-1:0] irq_in;
  logic             mask_we;
  logic [N_IRQ-1:0] mask_din;
  logic             intr_ack;
  logic             intr_ret;
  logic             intr_req;
  logic [VEC_W-1:0] intr_vec;
  logic [N_IRQ-1:0] in_service;
  logic [N_IRQ-1:0] pending;
  logic [N_IRQ-1:0] mask_q;

  // CPU / peripheral side
  modport master (
    output irq_in, mask_we, mask_din, intr_ack, intr_ret,
    input  intr_req, intr_vec, in_service, pending, mask_q
  );

  // Interrupt controller side
  modport slave (
    input  irq_in, mask_we, mask_din, intr_ack, intr_ret,
    output intr_req, intr_vec, in_service, pending, mask_q
  );
endinterface

// File: rtl/intr_ctrl.sv
// Prioritised interrupt controller (index 0 = highest priority).
// Latches rising edges into a pending register, masks them, requests the
// control unit and tracks in-service levels for nesting and return.
// Optional macro INTR_NEST_EN: when defined a higher-priority line may
// preempt a running handler; otherwise only one handler is in service.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | no request outstanding; looking for an eligible candidate
// S_REQ  | intr_req high, index and vector frozen until intr_ack
// S_HOLD | one quiet cycle after acknowledge while PC/stack settle
module intr_ctrl #(
  parameter int              N_IRQ      = 8,
  parameter int              VEC_W      = 10,
  parameter logic [VEC_W-1:0] VEC_BASE  = VEC_W'(10'h3F0),
  parameter int              VEC_STRIDE = 2
) (
  input  logic   clk,
  input  logic   reset,
  intr_if.slave  bus
);

  localparam int IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_t;

  state_t           state_q, state_d;
  logic [N_IRQ-1:0] irq_q;
  logic [N_IRQ-1:0] pend_q, pend_d;
  logic [N_IRQ-1:0] isr_q, isr_d;
  logic [N_IRQ-1:0] mask_r;
  logic [IDX_W-1:0] idx_q;
  logic [VEC_W-1:0] vec_q;

  logic [N_IRQ-1:0] edge_det;
  logic [N_IRQ-1:0] cand_vec;
  logic             cand_valid;
  logic [IDX_W-1:0] cand_idx;
  logic [N_IRQ-1:0] isr_low;
  logic             isr_any;
  logic [N_IRQ-1:0] isr_ret;
  logic [N_IRQ-1:0] idx_onehot;
  logic [VEC_W-1:0] vec_nxt;
  logic             eligible;
  logic             load;
  logic             take;

  assign edge_det   = bus.irq_in & ~irq_q;
  assign cand_vec   = pend_q & mask_r;
  assign isr_any    = |isr_q;
  assign idx_onehot = N_IRQ'(1) << idx_q;
  assign vec_nxt    = VEC_BASE + VEC_W'(cand_idx) * VEC_W'(VEC_STRIDE);

  // Lowest-index (highest-priority) enabled pending line
  always_comb begin
    cand_valid = 1'b0;
    cand_idx   = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (cand_vec[i]) begin
        cand_valid = 1'b1;
        cand_idx   = IDX_W'(i);
      end
    end
  end

  // One-hot of the current (lowest set) in-service level
  always_comb begin
    isr_low = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (isr_q[i]) begin
        isr_low    = '0;
        isr_low[i] = 1'b1;
      end
    end
  end

`ifdef INTR_NEST_EN
  logic [IDX_W-1:0] cur_lvl;

  // Index of the current in-service level for preemption compare
  always_comb begin
    cur_lvl = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (isr_q[i]) cur_lvl = IDX_W'(i);
    end
  end

  assign eligible = cand_valid && (!isr_any || (cand_idx < cur_lvl));
`else
  assign eligible = cand_valid && !isr_any;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and handshake strobes
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    take    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (eligible) begin
          state_d = S_REQ;
          load    = 1'b1;
        end
      end
      S_REQ: begin
        if (bus.intr_ack) begin
          take    = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_HOLD:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Return clears the old lowest level first; an acknowledge then sets its bit.
  // A fresh edge on the acknowledged line keeps it pending.
  always_comb begin
    isr_ret = bus.intr_ret ? (isr_q & ~isr_low) : isr_q;
    isr_d   = take ? (isr_ret | idx_onehot) : isr_ret;
    pend_d  = (take ? (pend_q & ~idx_onehot) : pend_q) | edge_det;
  end

  // Edge history, pending, in-service and mask registers
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q  <= '0;
      pend_q <= '0;
      isr_q  <= '0;
      mask_r <= '1;
    end else begin
      irq_q  <= bus.irq_in;
      pend_q <= pend_d;
      isr_q  <= isr_d;
      if (bus.mask_we) mask_r <= bus.mask_din;
    end
  end

  // Request index and vector, frozen once the request is raised
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q <= '0;
      vec_q <= '0;
    end else if (load) begin
      idx_q <= cand_idx;
      vec_q <= vec_nxt;
    end
  end

  assign bus.intr_req   = (state_q == S_REQ);
  assign bus.intr_vec   = vec_q;
  assign bus.in_service = isr_q;
  assign bus.pending    = pend_q;
  assign bus.mask_q     = mask_r;

endmodule

// File: tb/tb_intr_ctrl.sv
// Bench for intr_ctrl: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a behavioural model.
module tb_intr_ctrl;
  localparam int N      = 8;
  localparam int VW     = 10;
  localparam int BASE   = 'h3F0;
  localparam int STRIDE = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  intr_if #(.N_IRQ(N), .VEC_W(VW)) bus ();

  intr_ctrl #(
    .N_IRQ(N), .VEC_W(VW), .VEC_BASE(10'h3F0), .VEC_STRIDE(STRIDE)
  ) u_dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  typedef struct packed {
    logic [7:0] prev;
    logic [7:0] pend;
    logic [7:0] isr;
    logic [7:0] mask;
    logic [1:0] phase;   // 0 waiting, 1 requesting, 2 settling
    logic [2:0] idx;
    logic [9:0] vec;
  } mstate_t;

  mstate_t ms;

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic mstate_t model_step(input mstate_t s, input logic rst,
      input logic [7:0] irq, input logic mwe, input logic [7:0] mdin,
      input logic ack, input logic ret);
    mstate_t n;
    int cand, lvl, v;
    bit elig;
    n = s;
    if (rst) begin
      n = '0;
      n.mask = 8'hFF;
      return n;
    end
    cand = lowest(s.pend & s.mask);
    lvl  = lowest(s.isr);
`ifdef INTR_NEST_EN
    elig = (cand >= 0) && (lvl < 0 || cand < lvl);
`else
    elig = (cand >= 0) && (lvl < 0);
`endif
    if (ret && lvl >= 0) n.isr[lvl] = 1'b0;
    case (s.phase)
      2'd0: if (elig) begin
        n.phase = 2'd1;
        n.idx   = 3'(cand);
        v       = (BASE + cand * STRIDE) % 1024;
        n.vec   = 10'(v);
      end
      2'd1: if (ack) begin
        n.isr[s.idx]  = 1'b1;
        n.pend[s.idx] = 1'b0;
        n.phase       = 2'd2;
      end
      default: n.phase = 2'd0;
    endcase
    n.pend = n.pend | (irq & ~s.prev);
    n.prev = irq;
    if (mwe) n.mask = mdin;
    return n;
  endfunction

  always @(posedge clk)
    ms <= model_step(ms, reset, bus.irq_in, bus.mask_we, bus.mask_din,
                     bus.intr_ack, bus.intr_ret);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (check_en) begin
      chk("m_req", 32'(bus.intr_req), 32'(ms.phase == 2'd1));
      if (ms.phase == 2'd1) chk("m_vec", 32'(bus.intr_vec), 32'(ms.vec));
      chk("m_isr",  32'(bus.in_service), 32'(ms.isr));
      chk("m_pend", 32'(bus.pending), 32'(ms.pend));
      chk("m_mask", 32'(bus.mask_q), 32'(ms.mask));
`ifndef INTR_NEST_EN
      chk("m_one_isr", 32'($countones(bus.in_service) <= 1), 32'd1);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int line);
    bus.irq_in = 8'(1 << line);
    tick();
    bus.irq_in = '0;
  endtask

  task automatic do_ack();
    bus.intr_ack = 1'b1;
    tick();
    bus.intr_ack = 1'b0;
  endtask

  task automatic do_ret();
    bus.intr_ret = 1'b1;
    tick();
    bus.intr_ret = 1'b0;
  endtask

  initial begin
    bus.irq_in   = '0;
    bus.mask_we  = 1'b0;
    bus.mask_din = '0;
    bus.intr_ack = 1'b0;
    bus.intr_ret = 1'b0;
    reset = 1'b1;
    tick();
    check_en = 1'b1;
    tick();
    chk("rst_req",  32'(bus.intr_req), 32'd0);
    chk("rst_vec",  32'(bus.intr_vec), 32'd0);
    chk("rst_isr",  32'(bus.in_service), 32'd0);
    chk("rst_pend", 32'(bus.pending), 32'd0);
    chk("rst_mask", 32'(bus.mask_q), 32'hFF);
    reset = 1'b0;

    // T1: single line
    pulse(3);
    chk("t1_pend", 32'(bus.pending), 32'h08);
    chk("t1_req0", 32'(bus.intr_req), 32'd0);
    tick();
    chk("t1_req", 32'(bus.intr_req), 32'd1);
    chk("t1_vec", 32'(bus.intr_vec), 32'h3F6);
    do_ack();
    chk("t1_isr",   32'(bus.in_service), 32'h08);
    chk("t1_pend0", 32'(bus.pending), 32'h00);
    chk("t1_reqd",  32'(bus.intr_req), 32'd0);
    tick();
    do_ret();
    chk("t1_ret", 32'(bus.in_service), 32'h00);

    // T2: simultaneous lines, priority order
    bus.irq_in = 8'h24;
    tick();
    bus.irq_in = '0;
    tick();
    chk("t2_req", 32'(bus.intr_req), 32'd1);
    chk("t2_vec", 32'(bus.intr_vec), 32'h3F4);
    do_ack();
    chk("t2_isr",  32'(bus.in_service), 32'h04);
    chk("t2_pend", 32'(bus.pending), 32'h20);
    tick();
    tick();
    chk("t2_wait", 32'(bus.intr_req), 32'd0);
    do_ret();
    chk("t2_ret", 32'(bus.in_service), 32'h00);
    tick();
    chk("t2_req5", 32'(bus.intr_req), 32'd1);
    chk("t2_vec5", 32'(bus.intr_vec), 32'h3FA);
    do_ack();
    chk("t2_isr5", 32'(bus.in_service), 32'h20);
    tick();
    do_ret();
    chk("t2_clean", 32'(bus.in_service | bus.pending), 32'h00);

    // T3: higher-priority arrival while a handler runs
    pulse(4);
    tick();
    do_ack();
    tick();
    chk("t3_isr4", 32'(bus.in_service), 32'h10);
    pulse(1);
    tick();
`ifdef INTR_NEST_EN
    chk("t3_req", 32'(bus.intr_req), 32'd1);
    chk("t3_vec", 32'(bus.intr_vec), 32'h3F2);
    do_ack();
    chk("t3_nest", 32'(bus.in_service), 32'h12);
    tick();
    do_ret();
    chk("t3_ret1", 32'(bus.in_service), 32'h10);
    do_ret();
    chk("t3_ret2", 32'(bus.in_service), 32'h00);
`else
    chk("t3_noreq", 32'(bus.intr_req), 32'd0);
    do_ret();
    chk("t3_ret", 32'(bus.in_service), 32'h00);
    tick();
    chk("t3_req", 32'(bus.intr_req), 32'd1);
    chk("t3_vec", 32'(bus.intr_vec), 32'h3F2);
    do_ack();
    chk("t3_isr1", 32'(bus.in_service), 32'h02);
    tick();
    do_ret();
    chk("t3_done", 32'(bus.in_service), 32'h00);
`endif

    // T4: masking retains pending
    bus.mask_we = 1'b1; bus.mask_din = 8'hF7;
    tick();
    bus.mask_we = 1'b0;
    chk("t4_mask", 32'(bus.mask_q), 32'hF7);
    pulse(3);
    tick();
    chk("t4_pend",  32'(bus.pending), 32'h08);
    chk("t4_noreq", 32'(bus.intr_req), 32'd0);
    bus.mask_we = 1'b1; bus.mask_din = 8'hFF;
    tick();
    bus.mask_we = 1'b0;
    tick();
    chk("t4_req", 32'(bus.intr_req), 32'd1);
    chk("t4_vec", 32'(bus.intr_vec), 32'h3F6);
    do_ack();
    tick();
    do_ret();

    // T5: same-cycle events
    pulse(3);
    tick();
    bus.intr_ack = 1'b1; bus.irq_in = 8'h08;
    tick();
    bus.intr_ack = 1'b0; bus.irq_in = '0;
    chk("t5_isr",  32'(bus.in_service), 32'h08);
    chk("t5_pend", 32'(bus.pending), 32'h08);
    tick();
    pulse(1);
    tick();
`ifndef INTR_NEST_EN
    chk("t5_noreq", 32'(bus.intr_req), 32'd0);
    do_ret();
    tick();
`endif
    chk("t5_req", 32'(bus.intr_req), 32'd1);
    chk("t5_vec", 32'(bus.intr_vec), 32'h3F2);
    bus.intr_ack = 1'b1; bus.intr_ret = 1'b1;
    tick();
    bus.intr_ack = 1'b0; bus.intr_ret = 1'b0;
    chk("t5_ackret", 32'(bus.in_service), 32'h02);
    chk("t5_pend3",  32'(bus.pending), 32'h08);

    // T6: reset mid-handshake
    reset = 1'b1;
    tick();
    reset = 1'b0;
    pulse(6);
    tick();
    chk("t6_req", 32'(bus.intr_req), 32'd1);
    chk("t6_vec", 32'(bus.intr_vec), 32'h3FC);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_req0", 32'(bus.intr_req), 32'd0);
    chk("t6_vec0", 32'(bus.intr_vec), 32'd0);
    chk("t6_mask", 32'(bus.mask_q), 32'hFF);
    chk("t6_pend", 32'(bus.pending), 32'h00);
    do_ack();
    chk("t6_isr", 32'(bus.in_service), 32'h00);
    chk("t6_req1", 32'(bus.intr_req), 32'd0);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      bus.irq_in   = 8'($urandom) & 8'($urandom) & 8'($urandom);
      bus.mask_we  = ($urandom_range(0, 19) == 0);
      bus.mask_din = 8'($urandom) | 8'($urandom);
      bus.intr_ack = bus.intr_req ? ($urandom_range(0, 2) == 0)
                                  : ($urandom_range(0, 9) == 0);
      bus.intr_ret = ($urandom_range(0, 5) == 0);
      reset        = ($urandom_range(0, 499) == 0);
      tick();
    end
    bus.irq_in = '0; bus.mask_we = 1'b0; bus.intr_ack = 1'b0;
    bus.intr_ret = 1'b0; reset = 1'b0;
    tick();
    tick();
    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
